// File: rtl/multi_pwm_gen.sv
// Multi-channel PWM generator: one shared frame counter, per-channel set/reset
// windows, and double-buffered configuration that takes effect only at a frame boundary.
module multi_pwm_gen #(
    parameter int NCH   = 4,
    parameter int WIDTH = 7,
    parameter int CHW   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] period,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [WIDTH-1:0] cfg_set,
    input  logic [WIDTH-1:0] cfg_rst,
    input  logic             cfg_pol,
    input  logic             cfg_chen,
    input  logic             commit,
    output logic             busy,
    output logic             frame_start,
    output logic [WIDTH-1:0] cnt,
    output logic [NCH-1:0]   signal,
    output logic [NCH-1:0]   set_p,
    output logic [NCH-1:0]   rst_p
);

    logic [WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
    logic             busy_q, busy_d, frame_start_q, frame_start_d;

    logic [NCH-1:0][WIDTH-1:0] stg_set_q, stg_set_d, stg_rst_q, stg_rst_d;
    logic [NCH-1:0][WIDTH-1:0] act_set_q, act_set_d, act_rst_q, act_rst_d;
    logic [NCH-1:0] stg_pol_q, stg_pol_d, stg_chen_q, stg_chen_d;
    logic [NCH-1:0] act_pol_q, act_pol_d, act_chen_q, act_chen_d;
    logic [NCH-1:0] state_q, state_d, signal_q, signal_d;
    logic [NCH-1:0] set_p_q, set_p_d, rst_p_q, rst_p_d;
    logic [NCH-1:0] fire_set_s, fire_rst_s;

    logic run_s, last_s, apply_s;

    // Frame counter, commit handshake and the apply decision
    always_comb begin
        run_s   = en && (period_q >= WIDTH'(2));
        last_s  = (cnt_q == (period_q - WIDTH'(1)));
        apply_s = busy_q && (last_s || !en || (period_q < WIDTH'(2)));
        if (apply_s) begin
            cnt_d         = {WIDTH{1'b0}};
            period_d      = period;
            frame_start_d = en && (period >= WIDTH'(2));
        end else begin
            period_d      = period_q;
            frame_start_d = run_s && last_s;
            if (run_s && !last_s) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else begin
                cnt_d = {WIDTH{1'b0}};
            end
        end
        if (busy_q) begin
            busy_d = !apply_s;
        end else begin
            busy_d = commit;
        end
    end

    // Staging writes and staging-to-active transfer (pre-edge staging is what gets applied)
    always_comb begin
        stg_set_d  = stg_set_q;
        stg_rst_d  = stg_rst_q;
        stg_pol_d  = stg_pol_q;
        stg_chen_d = stg_chen_q;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_we && (cfg_ch == CHW'(i))) begin
                stg_set_d[i]  = cfg_set;
                stg_rst_d[i]  = cfg_rst;
                stg_pol_d[i]  = cfg_pol;
                stg_chen_d[i] = cfg_chen;
            end else begin
                stg_set_d[i]  = stg_set_q[i];
            end
        end
        if (apply_s) begin
            act_set_d  = stg_set_q;
            act_rst_d  = stg_rst_q;
            act_pol_d  = stg_pol_q;
            act_chen_d = stg_chen_q;
        end else begin
            act_set_d  = act_set_q;
            act_rst_d  = act_rst_q;
            act_pol_d  = act_pol_q;
            act_chen_d = act_chen_q;
        end
    end

    // Per-channel set/reset events; the output level uses the configuration in force after the edge
    always_comb begin
        fire_set_s = {NCH{1'b0}};
        fire_rst_s = {NCH{1'b0}};
        state_d    = state_q;
        signal_d   = signal_q;
        set_p_d    = {NCH{1'b0}};
        rst_p_d    = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            fire_rst_s[i] = run_s && act_chen_q[i] && (cnt_q == act_rst_q[i]);
            fire_set_s[i] = run_s && act_chen_q[i] && !fire_rst_s[i] && (cnt_q == act_set_q[i]);
            if (!en || fire_rst_s[i]) begin
                state_d[i] = 1'b0;
            end else if (fire_set_s[i]) begin
                state_d[i] = 1'b1;
            end else begin
                state_d[i] = state_q[i];
            end
            if (!act_chen_d[i]) begin
                state_d[i] = 1'b0;
            end else begin
                state_d[i] = state_d[i];
            end
            set_p_d[i]  = fire_set_s[i] && !state_q[i] && state_d[i];
            rst_p_d[i]  = fire_rst_s[i] && state_q[i];
            signal_d[i] = (state_d[i] & act_chen_d[i]) ^ act_pol_d[i];
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= {WIDTH{1'b0}};
            period_q      <= {WIDTH{1'b0}};
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            stg_set_q     <= '0;
            stg_rst_q     <= '0;
            stg_pol_q     <= {NCH{1'b0}};
            stg_chen_q    <= {NCH{1'b0}};
            act_set_q     <= '0;
            act_rst_q     <= '0;
            act_pol_q     <= {NCH{1'b0}};
            act_chen_q    <= {NCH{1'b0}};
            state_q       <= {NCH{1'b0}};
            signal_q      <= {NCH{1'b0}};
            set_p_q       <= {NCH{1'b0}};
            rst_p_q       <= {NCH{1'b0}};
        end else begin
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
            stg_set_q     <= stg_set_d;
            stg_rst_q     <= stg_rst_d;
            stg_pol_q     <= stg_pol_d;
            stg_chen_q    <= stg_chen_d;
            act_set_q     <= act_set_d;
            act_rst_q     <= act_rst_d;
            act_pol_q     <= act_pol_d;
            act_chen_q    <= act_chen_d;
            state_q       <= state_d;
            signal_q      <= signal_d;
            set_p_q       <= set_p_d;
            rst_p_q       <= rst_p_d;
        end
    end

    assign cnt         = cnt_q;
    assign busy        = busy_q;
    assign frame_start = frame_start_q;
    assign signal      = signal_q;
    assign set_p       = set_p_q;
    assign rst_p       = rst_p_q;

endmodule

// File: doc/multi_pwm_gen.md
Name: multi_pwm_gen

Overview:
- N-channel successor of the single-channel photonic-switch PWM generator.
- One shared period counter drives every channel. Each channel has its own set time, reset time, polarity and enable.
- Configuration is double-buffered: new values are written into staging registers and take effect only at a frame boundary, so switches never see a torn pulse.
- Sits between the control register interface and the photonic switch drivers.

Parameters:
NCH, 4, number of PWM channels (1..16)
WIDTH, 7, bit width of period, set and reset times
CHW, 2, width of channel index (>= clog2(NCH), min 1)

Ports:
clk  in  1  core clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
en  in  1  run enable for the period counter
period  in  WIDTH  frame length in clk cycles; sampled only at frame boundary
cfg_we  in  1  write staging registers of channel cfg_ch
cfg_ch  in  CHW  channel index for cfg_we
cfg_set  in  WIDTH  count value at which channel goes active
cfg_rst  in  WIDTH  count value at which channel goes inactive
cfg_pol  in  1  1 = active-low output
cfg_chen  in  1  channel enable
commit  in  1  one-cycle request to apply all staged values
busy  out  1  commit pending, not yet applied
frame_start  out  1  one-cycle pulse when counter wraps to 0
cnt  out  WIDTH  current period count
signal  out  NCH  PWM outputs
set_p  out  NCH  one-cycle pulse on each channel's set event
rst_p  out  NCH  one-cycle pulse on each channel's reset event

Behaviour:
- Reset (reset_n low, async):
  - cnt=0, busy=0, frame_start=0, set_p=0, rst_p=0, signal=0.
  - All staging and active registers: set=0, rst=0, pol=0, chen=0.
  - Active period = 0.
- Staging:
  - cfg_we writes staging[cfg_ch] on the clock edge.
  - cfg_ch >= NCH: write ignored.
  - cfg_we has no effect on outputs until applied.
- Commit:
  - commit sets busy=1 next cycle.
  - Repeated commit while busy: no extra effect.
  - cfg_we while busy is allowed; the latest staged values at the apply edge are used.
- Apply:
  - Happens on the edge where busy=1 and (cnt == active_period-1, or en=0, or active_period < 2).
  - Copies all staging to active, samples the period input into active_period, clears busy.
  - On that same edge, cnt <= 0.
- Counter:
  - While en=1 and active_period >= 2: cnt increments each cycle and wraps from active_period-1 to 0.
  - frame_start is registered, high for the cycle in which cnt==0 after a wrap or after an apply.
  - en=0: cnt held at 0, frame_start=0.
  - active_period of 0 or 1: cnt held at 0, no events.
- Channel state:
  - Internal state bit per channel, updated on each edge with the pre-edge cnt value:
    - cnt==rst: state<=0 (reset has priority).
    - else cnt==set: state<=1.
    - else hold.
  - set==rst: channel permanently inactive.
  - set or rst >= active_period: that event never fires.
  - set > rst: pulse wraps across the frame boundary; this is legal.
  - set_p/rst_p are high in the same cycle the state changes, and only when the state actually changes.
- Outputs:
  - signal[i] = (state[i] & chen[i]) XOR pol[i], registered.
  - Latency: signal changes on the first edge after cnt shows the match value.
  - chen=0: state forced 0, signal = pol, no pulses.
- en falling mid-frame: all states cleared to 0 on the next edge; outputs go to their idle level (pol).
- Reset mid-frame: immediate return to reset values; a pending commit is lost.

Test Plan:
1. Reset release, write ch0 set=2 rst=5 chen=1, period=10, commit, en=1 -> busy=1 for 1 cycle, apply (en path); signal[0] high in cycles with cnt 3..5, low otherwise; period 10 cycles; frame_start every 10.
2. Running at period=10, ch1 set=8 rst=2 -> wrap pulse: signal[1] high for cnt 9,0,1,2 (4 cycles), set_p at cnt=9, rst_p at cnt=3.
3. Mid-frame (cnt=4) commit of ch0 set=1 rst=3 period=6 -> busy stays 1 until cnt==9; new pattern starts at next frame_start; no truncated or merged pulse on signal[0].
4. Edge values: set==rst=4 -> signal stuck idle, no pulses. rst=12 with period=10 -> output stays active after set. period=1 -> cnt stuck at 0, no events. cfg_ch=NCH -> no change.
5. pol=1, chen toggled 0/1 via commit -> idle level 1, active level 0; chen=0 forces signal=1 with no pulses.
6. Assert reset_n low at cnt=5 with commit pending -> all outputs 0 asynchronously, busy=0; after release, old staging is cleared and no pulses occur.
